// File: rtl/score_text_pkg.sv
// Shared constants and types for the status text overlay.
// Used by the score line controller and its BCD converter.
package score_text_pkg;

  localparam logic [6:0] SPACE      = 7'h20;
  localparam logic [6:0] ASCII_ZERO = 7'h30;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  function automatic int unsigned max_score(input int unsigned digits);
    int unsigned m;
    m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    return m - 1;
  endfunction

endpackage

// File: rtl/score_text_ctrl_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter with valid/ready input.
// Saturates the input to the largest displayable value.
module bin2bcd_seq
  import score_text_pkg::*;
#(
  parameter int SCORE_W = 14,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SCORE_W-1:0]    score_in,
  input  logic                  score_valid,
  output logic                  score_ready,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int unsigned          MAX   = max_score(DIGITS);
  localparam logic [SCORE_W-1:0]   MAX_V = SCORE_W'(MAX);

  state_t                state;
  state_t                state_nx;
  logic [SCORE_W-1:0]    bin;
  logic [4*DIGITS-1:0]   work;
  logic [4*DIGITS-1:0]   adj;
  logic [SCORE_W-1:0]    sat;
  logic [4:0]            cnt;

  assign sat = (32'(score_in) > MAX) ? MAX_V : score_in;
  assign bcd = work;

  // Per-nibble correction; no carry crosses nibble boundaries
  always_comb begin
    adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nx    = state;
    score_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        score_ready = 1'b1;
        if (score_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == 5'(SCORE_W - 1)) state_nx = COMMIT;
      end
      COMMIT: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bin   <= '0;
      work  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (score_valid) begin
            bin  <= sat;
            work <= '0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          {work, bin} <= {adj[4*DIGITS-2:0], bin, 1'b0};
          cnt         <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/score_text_ctrl.sv
// Score line of the status overlay: label ROM lookup plus a
// blanked decimal score, served one registered character at a time.
module score_text_ctrl
  import score_text_pkg::*;
#(
  parameter int SCORE_W   = 14,
  parameter int DIGITS    = 4,
  parameter int LABEL_LEN = 5,
  parameter int DIGIT_COL = 6,
  parameter int BLANK_LZ  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               score_valid,
  output logic               score_ready,
  output logic               busy,
  input  logic [7:0]         char_xy,
  output logic [6:0]         char_code,
  output logic [7:0]         rom_xy,
  input  logic [6:0]         rom_code
);

  logic [4*DIGITS-1:0] bcd;
  logic [4*DIGITS-1:0] digits;
  logic                done;
  logic [6:0]          code_nx;
  logic [3:0]          row;
  logic [3:0]          col;
  logic [3:0]          nib;
  logic                lead;

  bin2bcd_seq #(
    .SCORE_W (SCORE_W),
    .DIGITS  (DIGITS)
  ) u_conv (
    .clk         (clk),
    .rst         (rst),
    .score_in    (score_in),
    .score_valid (score_valid),
    .score_ready (score_ready),
    .busy        (busy),
    .bcd         (bcd),
    .done        (done)
  );

  assign row    = char_xy[7:4];
  assign col    = char_xy[3:0];
  assign rom_xy = {4'h0, col};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) digits <= '0;
    else if (done) digits <= bcd;
  end

  // lead stays set while every digit so far (MSD first) is zero
  always_comb begin
    code_nx = SPACE;
    lead    = 1'b1;
    nib     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib  = digits[4*(DIGITS-1-i) +: 4];
      lead = lead & (nib == 4'd0);
      if (row == 4'd0 && int'(col) == DIGIT_COL + i) begin
        if (BLANK_LZ != 0 && lead && i != DIGITS - 1)
          code_nx = SPACE;
        else
          code_nx = ASCII_ZERO + {3'b000, nib};
      end
    end
    if (row == 4'd0 && int'(col) < LABEL_LEN)
      code_nx = rom_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) char_code <= SPACE;
    else char_code <= code_nx;
  end

endmodule
